// File: rtl/kvs_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide key/value memory port between the
// SET writer (requester 0) and the GET reader (requester 1), one burst at a time.
module kvs_mem_arbiter #(
   parameter int RD_LAT = 1,
   parameter int ADDR_W = 17,
   parameter int LEN_W  = 11
) (
   input  logic                gtx_clk,
   input  logic                sys_rst,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*LEN_W-1:0]  len,
   input  logic [15:0]         wdata,
   output logic [1:0]          data_rd,
   output logic [1:0]          grant,
   output logic [7:0]          rdata,
   output logic [1:0]          rvalid,
   output logic [1:0]          done,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [7:0]          mem_data,
   output logic                mem_wr_en,
   input  logic [7:0]          mem_q
);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                rr_last;
   logic                cur_id;
   logic                cur_we;
   logic [ADDR_W-1:0]   cur_addr;
   logic [LEN_W-1:0]    remaining;
   logic [RD_LAT:0]     pipe_v;
   logic [RD_LAT:0]     pipe_id;

   logic                sel_id;
   logic                start;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [LEN_W-1:0]    sel_len;
   logic [7:0]          cur_wdata;
   logic                push;

   // Request selection; done still high means the previous burst is just
   // closing, so that cycle is deliberately skipped.
   always_comb begin
      sel_id    = (req == 2'b11) ? ~rr_last : req[1];
      start     = (state == IDLE) && (req != 2'b00) && (done == 2'b00);
      sel_we    = sel_id ? we[1] : we[0];
      sel_addr  = sel_id ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
      sel_len   = sel_id ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
      cur_wdata = cur_id ? wdata[15:8] : wdata[7:0];
      push      = (state == BURST) && !cur_we;
   end

   always_comb begin
      state_nxt = state;
      data_rd   = 2'b00;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (sel_len == '0) ? DONE : BURST;
            end
         end
         BURST: begin
            if (cur_we) begin
               data_rd[cur_id] = 1'b1;
            end
            if (remaining == LEN_W'(1)) begin
               state_nxt = cur_we ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            // Leave once only the final stage is occupied: the last rvalid
            // then lands in the DONE cycle.
            if (pipe_v[RD_LAT-1:0] == '0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge gtx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge gtx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rr_last     <= 1'b1;
         cur_id      <= 1'b0;
         cur_we      <= 1'b0;
         cur_addr    <= '0;
         remaining   <= '0;
         pipe_v      <= '0;
         pipe_id     <= '0;
         grant       <= 2'b00;
         done        <= 2'b00;
         rvalid      <= 2'b00;
         rdata       <= 8'h00;
         mem_address <= '0;
         mem_data    <= 8'h00;
         mem_wr_en   <= 1'b0;
      end else begin
         mem_wr_en <= 1'b0;
         done      <= 2'b00;
         rvalid    <= 2'b00;
         pipe_v    <= {pipe_v[RD_LAT-1:0], push};
         pipe_id   <= {pipe_id[RD_LAT-1:0], cur_id};
         if (pipe_v[RD_LAT]) begin
            rvalid[pipe_id[RD_LAT]] <= 1'b1;
            rdata                   <= mem_q;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  cur_id    <= sel_id;
                  cur_we    <= sel_we;
                  cur_addr  <= sel_addr;
                  remaining <= sel_len;
                  grant     <= sel_id ? 2'b10 : 2'b01;
               end
            end
            BURST: begin
               mem_address <= cur_addr;
               cur_addr    <= cur_addr + 1'b1;
               remaining   <= remaining - 1'b1;
               if (cur_we) begin
                  mem_wr_en <= 1'b1;
                  mem_data  <= cur_wdata;
               end
            end
            DONE: begin
               done    <= cur_id ? 2'b10 : 2'b01;
               grant   <= 2'b00;
               rr_last <= cur_id;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kvs_mem_arbiter.sv
// Bench for kvs_mem_arbiter: table of bursts with fixed expected latencies,
// a byte-wide memory model, and write/read scoreboards fed at issue time.
module tb_kvs_mem_arbiter;

   localparam int RD_LAT = 1;

   logic        gtx_clk;
   logic        sys_rst;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [33:0] addr;
   logic [21:0] len;
   logic [15:0] wdata;
   logic [1:0]  data_rd;
   logic [1:0]  grant;
   logic [7:0]  rdata;
   logic [1:0]  rvalid;
   logic [1:0]  done;
   logic [16:0] mem_address;
   logic [7:0]  mem_data;
   logic        mem_wr_en;
   logic [7:0]  mem_q;

   kvs_mem_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(17), .LEN_W(11)) dut (
      .gtx_clk     (gtx_clk),
      .sys_rst     (sys_rst),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .len         (len),
      .wdata       (wdata),
      .data_rd     (data_rd),
      .grant       (grant),
      .rdata       (rdata),
      .rvalid      (rvalid),
      .done        (done),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wr_en   (mem_wr_en),
      .mem_q       (mem_q)
   );

   // clock / reset
   initial gtx_clk = 1'b0;
   always #5 gtx_clk = ~gtx_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // memory model with one cycle of read latency
   logic [7:0] mem    [0:131071];
   logic [7:0] shadow [0:131071];

   always @(posedge gtx_clk) begin
      if (mem_wr_en) mem[mem_address] <= mem_data;
      mem_q <= mem[mem_address];
   end

   // scoreboard
   int total = 0;
   int bad   = 0;
   logic        mon_en = 1'b1;
   logic [24:0] exp_wr_q[$];
   logic [9:0]  exp_rd_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge gtx_clk) begin
      if (!sys_rst && mon_en) begin
         if (mem_wr_en) begin
            if (exp_wr_q.size() == 0) chk("unexpected_write", {7'd0, mem_address, mem_data}, 32'hFFFF_FFFF);
            else chk("mem_write", {7'd0, mem_address, mem_data}, {7'd0, exp_wr_q.pop_front()});
         end
         if (rvalid != 2'b00) begin
            if (exp_rd_q.size() == 0) chk("unexpected_rvalid", {22'd0, rvalid, rdata}, 32'hFFFF_FFFF);
            else chk("read_data", {22'd0, rvalid, rdata}, {22'd0, exp_rd_q.pop_front()});
         end
         if (grant != 2'b00) chk("grant_onehot", $countones(grant), 1);
      end
   end

   // driver
   typedef struct {
      logic        id;
      logic        we;
      logic [16:0] a;
      logic [10:0] n;
      int          lat;
   } vec_t;

   vec_t       tbl [8];
   logic [7:0] wbuf [16];

   task automatic drive_req(input logic id, input logic w, input logic [16:0] a, input logic [10:0] n);
      if (id) begin
         addr[33:17] = a; len[21:11] = n; we[1] = w; req[1] = 1'b1;
      end else begin
         addr[16:0] = a; len[10:0] = n; we[0] = w; req[0] = 1'b1;
      end
   endtask

   task automatic do_burst(input vec_t v);
      logic        got;
      logic [16:0] ra;
      logic [1:0]  oh;
      int          k, c, lat, nrd, nrv, first_rv;
      oh = v.id ? 2'b10 : 2'b01;
      drive_req(v.id, v.we, v.a, v.n);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge gtx_clk);
         if (grant[v.id]) got = 1'b1;
      end
      if (!got) begin
         chk("grant_timeout", 0, 1);
         req = 2'b00;
         return;
      end
      chk("grant_owner", grant, oh);
      if (!v.we) begin
         for (int j = 0; j < int'(v.n); j++) begin
            ra = v.a + 17'(j);
            exp_rd_q.push_back({oh, shadow[ra]});
         end
      end
      // late changes to the request fields must not disturb the burst
      drive_req(v.id, ~v.we, 17'($urandom), 11'($urandom));
      k = 0; c = 0; lat = -1; nrd = 0; nrv = 0; first_rv = -1;
      while (c < 100 && lat < 0) begin
         if (data_rd[v.id]) begin
            nrd++;
            if (k < 16) begin
               ra = v.a + 17'(k);
               if (v.id) wdata[15:8] = wbuf[k]; else wdata[7:0] = wbuf[k];
               exp_wr_q.push_back({ra, wbuf[k]});
               shadow[ra] = wbuf[k];
               k++;
            end
         end
         if (rvalid[v.id]) begin
            if (first_rv < 0) first_rv = c;
            nrv++;
         end
         if (done[v.id]) lat = c;
         else begin
            @(negedge gtx_clk);
            c++;
         end
      end
      req[v.id] = 1'b0;
      chk("done_latency", lat, v.lat);
      chk("data_rd_count", nrd, v.we ? int'(v.n) : 0);
      chk("rvalid_count", nrv, v.we ? 0 : int'(v.n));
      if (!v.we && v.n != 0) chk("first_rvalid", first_rv, RD_LAT + 2);
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic apply_reset();
      @(negedge gtx_clk);
      sys_rst = 1'b1;
      req = 2'b00;
      @(negedge gtx_clk);
      @(negedge gtx_clk);
      sys_rst = 1'b0;
      @(negedge gtx_clk);
   endtask

   initial begin
      int   ngr, ndone, nbad_ev;
      logic [1:0] prev_g;
      logic [1:0] last_g;
      logic [16:0] ra;
      vec_t v;
      for (int i = 0; i < 131072; i++) begin
         mem[i] = 8'h00;
         shadow[i] = 8'h00;
      end
      sys_rst = 1'b1; req = 2'b00; we = 2'b00; addr = '0; len = '0; wdata = '0;
      #1;
      chk("reset_outputs", {15'd0, grant, done, rvalid, data_rd, mem_wr_en, rdata}, 0);
      chk("reset_mem_port", {7'd0, mem_address, mem_data}, 0);
      @(negedge gtx_clk);
      @(negedge gtx_clk);
      sys_rst = 1'b0;
      @(negedge gtx_clk);

      tbl[0] = '{id: 1'b0, we: 1'b1, a: 17'h00010, n: 11'd4, lat: 5};
      tbl[1] = '{id: 1'b1, we: 1'b0, a: 17'h00010, n: 11'd4, lat: 7};
      tbl[2] = '{id: 1'b0, we: 1'b1, a: 17'h1FFFF, n: 11'd3, lat: 4};
      tbl[3] = '{id: 1'b1, we: 1'b0, a: 17'h1FFFF, n: 11'd3, lat: 6};
      tbl[4] = '{id: 1'b0, we: 1'b1, a: 17'h00100, n: 11'd0, lat: 1};
      tbl[5] = '{id: 1'b1, we: 1'b0, a: 17'h00100, n: 11'd0, lat: 1};
      tbl[6] = '{id: 1'b1, we: 1'b1, a: 17'h00200, n: 11'd5, lat: 6};
      tbl[7] = '{id: 1'b0, we: 1'b0, a: 17'h00200, n: 11'd5, lat: 8};

      for (int t = 0; t < 8; t++) begin
         fill_random(16);
         if (t == 0) begin
            wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
         end
         do_burst(tbl[t]);
      end
      chk("shadow_0x10", {shadow[17'h10], shadow[17'h11], shadow[17'h12], shadow[17'h13]}, 32'hDEADBEEF);

      // random write then read-back through the opposite requester
      for (int r = 0; r < 3; r++) begin
         fill_random(16);
         v.id = r[0];
         v.we = 1'b1;
         v.a  = 17'($urandom_range(0, 131071));
         v.n  = 11'($urandom_range(1, 6));
         v.lat = int'(v.n) + 1;
         do_burst(v);
         v.id = ~v.id;
         v.we = 1'b0;
         v.lat = int'(v.n) + RD_LAT + 2;
         do_burst(v);
      end

      // simultaneous requests from reset: round-robin starting at requester 0
      apply_reset();
      we = 2'b00; len = '0; addr = '0;
      req = 2'b11;
      ngr = 0; ndone = 0; prev_g = 2'b00; last_g = 2'b00;
      for (int c = 0; c < 80 && ndone < 4; c++) begin
         @(negedge gtx_clk);
         if (grant != 2'b00 && prev_g == 2'b00) begin
            chk("arb_order", grant, ngr[0] ? 2'b10 : 2'b01);
            last_g = grant;
            ngr++;
         end
         if (done != 2'b00) begin
            chk("arb_done_id", done, last_g);
            chk("arb_done_no_grant", grant, 2'b00);
            ndone++;
         end
         prev_g = grant;
      end
      req = 2'b00;
      chk("arb_grant_count", ngr, 4);

      // reset in the second cycle of an 8-byte write
      fill_random(16);
      mon_en = 1'b0;
      drive_req(1'b0, 1'b1, 17'h00300, 11'd8);
      ngr = 0;
      for (int i = 0; i < 20 && ngr == 0; i++) begin
         @(negedge gtx_clk);
         if (grant[0]) ngr = 1;
      end
      chk("rst_burst_grant", ngr, 1);
      wdata[7:0] = wbuf[0];
      @(negedge gtx_clk);
      wdata[7:0] = wbuf[1];
      sys_rst = 1'b1;
      #1;
      chk("midburst_reset_outputs", {15'd0, grant, done, rvalid, data_rd, mem_wr_en, rdata}, 0);
      chk("midburst_reset_mem_port", {7'd0, mem_address, mem_data}, 0);
      req = 2'b00;
      @(negedge gtx_clk);
      @(negedge gtx_clk);
      sys_rst = 1'b0;
      nbad_ev = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge gtx_clk);
         if (done != 2'b00 || mem_wr_en || rvalid != 2'b00) nbad_ev++;
      end
      chk("no_activity_after_reset", nbad_ev, 0);
      ra = 17'h00300;
      chk("no_write_before_reset", {24'd0, mem[ra]}, {24'd0, shadow[ra]});
      exp_wr_q.delete();
      exp_rd_q.delete();
      mon_en = 1'b1;

      fill_random(16);
      v = '{id: 1'b0, we: 1'b1, a: 17'h00300, n: 11'd8, lat: 9};
      do_burst(v);
      v = '{id: 1'b1, we: 1'b0, a: 17'h00300, n: 11'd8, lat: 8 + RD_LAT + 2};
      do_burst(v);

      for (int i = 0; i < 6; i++) @(negedge gtx_clk);
      chk("wr_queue_empty", exp_wr_q.size(), 0);
      chk("rd_queue_empty", exp_rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
